// File: rtl/led_pkg.sv
// Shared types and defaults for the LED matrix test-pattern generator.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAR      = 2'd0,
    MODE_COL_SCROLL = 2'd1,
    MODE_ROW_SWEEP  = 2'd2,
    MODE_CHECKER    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_ROWS = 16;
  localparam int DEF_COLS = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running animation-step divider: tick is high while the count sits at DIV-1.
module tick_divider #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt_r;

  assign tick = en && (div_cnt_r == LAST);

  // Divider counter; clr wins over counting so a restart always begins at zero.
  always_ff @(posedge clk) begin
    if (RST) begin
      div_cnt_r <= {W{1'b0}};
    end else if (clr) begin
      div_cnt_r <= {W{1'b0}};
    end else if (en) begin
      if (tick) begin
        div_cnt_r <= {W{1'b0}};
      end else begin
        div_cnt_r <= div_cnt_r + W'(1'b1);
      end
    end else begin
      div_cnt_r <= div_cnt_r;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Animated test-pattern generator for the red/green LED matrix; pixels decode
// from registered state only.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int TICK_DIV = 25000000
) (
  input  logic                           clk,
  input  logic                           RST,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  output logic [ROWS-1:0][COLS-1:0]      RedPixels,
  output logic [ROWS-1:0][COLS-1:0]      GrnPixels,
  output logic                           frame_done
);

  localparam int MAXRC = max_int(ROWS, COLS);
  localparam int PW    = (MAXRC > 1) ? $clog2(MAXRC) : 1;

  state_e                  state_r, state_s;
  mode_e                   mode_q_r, mode_q_s;
  mode_e                   mode_in_s;
  logic [PW-1:0]           pos_r, pos_s, pos_nxt_s;
  logic                    wrap_s;
  logic                    frame_done_r, frame_done_s;
  logic                    div_clr_s, div_en_s, tick_s;
  logic [ROWS-1:0][COLS-1:0] red_s, grn_s;

  assign mode_in_s = mode_e'(mode);

  tick_divider #(.DIV(TICK_DIV)) u_div (
    .clk  (clk),
    .RST  (RST),
    .clr  (div_clr_s),
    .en   (div_en_s),
    .tick (tick_s)
  );

  // Position successor for the current pattern; wrap_s flags a return to 0.
  always_comb begin
    pos_nxt_s = {PW{1'b0}};
    wrap_s    = 1'b0;
    case (mode_q_r)
      MODE_COL_SCROLL: begin
        if (int'(pos_r) >= COLS - 1) begin
          wrap_s = 1'b1;
        end else begin
          pos_nxt_s = pos_r + PW'(1'b1);
        end
      end
      MODE_ROW_SWEEP: begin
        if (int'(pos_r) >= ROWS - 1) begin
          wrap_s = 1'b1;
        end else begin
          pos_nxt_s = pos_r + PW'(1'b1);
        end
      end
      MODE_CHECKER: begin
        if (int'(pos_r) >= 1) begin
          wrap_s = 1'b1;
        end else begin
          pos_nxt_s = pos_r + PW'(1'b1);
        end
      end
      MODE_CLEAR: pos_nxt_s = {PW{1'b0}};
      default:    pos_nxt_s = {PW{1'b0}};
    endcase
  end

  // Next-state logic; a mode change restarts the pattern and suppresses any tick.
  always_comb begin
    state_s      = state_r;
    mode_q_s     = mode_q_r;
    pos_s        = pos_r;
    frame_done_s = 1'b0;
    div_clr_s    = 1'b0;
    div_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        div_clr_s = 1'b1;
        pos_s     = {PW{1'b0}};
        if (enable) begin
          state_s  = ST_RUN;
          mode_q_s = mode_in_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_s   = ST_IDLE;
          div_clr_s = 1'b1;
          pos_s     = {PW{1'b0}};
        end else if (mode_in_s != mode_q_r) begin
          mode_q_s  = mode_in_s;
          div_clr_s = 1'b1;
          pos_s     = {PW{1'b0}};
        end else begin
          div_en_s = 1'b1;
          if (tick_s) begin
            pos_s        = pos_nxt_s;
            frame_done_s = wrap_s && (mode_q_r != MODE_CLEAR);
          end else begin
            pos_s = pos_r;
          end
        end
      end
      default: begin
        state_s   = ST_IDLE;
        div_clr_s = 1'b1;
        pos_s     = {PW{1'b0}};
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      mode_q_r     <= MODE_CLEAR;
      pos_r        <= {PW{1'b0}};
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      mode_q_r     <= mode_q_s;
      pos_r        <= pos_s;
      frame_done_r <= frame_done_s;
    end
  end

  // Pixel decode from registered state.
  always_comb begin
    red_s = '0;
    grn_s = '0;
    if (state_r == ST_RUN) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          case (mode_q_r)
            MODE_COL_SCROLL: grn_s[r][c] = (c == int'(pos_r));
            MODE_ROW_SWEEP:  red_s[r][c] = (r == int'(pos_r));
            MODE_CHECKER: begin
              red_s[r][c] = (((r + c) % 2) == int'(pos_r[0]));
              grn_s[r][c] = (((r + c) % 2) != int'(pos_r[0]));
            end
            MODE_CLEAR: begin
              red_s[r][c] = 1'b0;
              grn_s[r][c] = 1'b0;
            end
            default: begin
              red_s[r][c] = 1'b0;
              grn_s[r][c] = 1'b0;
            end
          endcase
        end
      end
    end else begin
      red_s = '0;
      grn_s = '0;
    end
  end

  assign RedPixels  = red_s;
  assign GrnPixels  = grn_s;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed + randomized bench for led_pattern_gen against a cycle-count based model.
module tb_led_pattern_gen;

  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int TD   = 4;

  logic                      clk = 1'b0;
  logic                      RST = 1'b1;
  logic                      enable = 1'b0;
  logic [1:0]                mode = 2'd0;
  logic [ROWS-1:0][COLS-1:0] RedPixels;
  logic [ROWS-1:0][COLS-1:0] GrnPixels;
  logic                      frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: pattern derived from cycles elapsed since the pattern started.
  bit m_active = 1'b0;
  int m_mode   = 0;
  int m_cyc    = 0;
  logic [ROWS-1:0][COLS-1:0] exp_red, exp_grn;
  logic exp_fd;
  int fd_count;

  led_pattern_gen #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD)) dut (
    .clk        (clk),
    .RST        (RST),
    .enable     (enable),
    .mode       (mode),
    .RedPixels  (RedPixels),
    .GrnPixels  (GrnPixels),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic int period_of(input int md);
    case (md)
      1: return COLS;
      2: return ROWS;
      3: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int cur_pos();
    return (m_cyc / TD) % period_of(m_mode);
  endfunction

  task automatic build_exp();
    logic [COLS-1:0] one;
    int p;
    one = {{(COLS-1){1'b0}}, 1'b1};
    exp_red = '0;
    exp_grn = '0;
    exp_fd  = 1'b0;
    if (m_active) begin
      p = cur_pos();
      for (int r = 0; r < ROWS; r++) begin
        case (m_mode)
          1: exp_grn[r] = one << p;
          2: exp_red[r] = (r == p) ? {COLS{1'b1}} : {COLS{1'b0}};
          3: begin
            exp_red[r] = (((r + p) % 2) == 0) ? 16'h5555 : 16'hAAAA;
            exp_grn[r] = ~exp_red[r];
          end
          default: ;
        endcase
      end
      exp_fd = (m_mode != 0) && (m_cyc > 0) && ((m_cyc % (TD * period_of(m_mode))) == 0);
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One clock: model follows the inputs seen at the edge, then outputs are compared.
  task automatic step();
    @(posedge clk);
    if (RST) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (enable) begin
        m_active = 1'b1;
        m_mode   = int'(mode);
        m_cyc    = 0;
      end
    end else if (!enable) begin
      m_active = 1'b0;
    end else if (int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_cyc  = 0;
    end else begin
      m_cyc++;
    end
    #1;
    build_exp();
    chk("red_plane", RedPixels, exp_red);
    chk("grn_plane", GrnPixels, exp_grn);
    chk("frame_done", {255'd0, frame_done}, {255'd0, exp_fd});
    if (frame_done === 1'b1) fd_count++;
  endtask

  initial begin
    int guard;
    // Reset and idle
    RST = 1'b1; enable = 1'b0; mode = 2'd0;
    step(); step();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("idle_dark", RedPixels | GrnPixels, 256'd0);

    // Column scroll
    enable = 1'b1; mode = 2'd1;
    step();
    chk("col_start", {240'd0, GrnPixels[5]}, {240'd0, 16'h0001});
    for (int i = 0; i < 4; i++) step();
    chk("col_step1", {240'd0, GrnPixels[9]}, {240'd0, 16'h0002});
    fd_count = 0;
    for (int i = 0; i < 60; i++) step();
    chk("col_wrap", {240'd0, GrnPixels[0]}, {240'd0, 16'h0001});
    chk("col_fd_once", fd_count, 1);

    // Row sweep
    mode = 2'd2;
    step();
    chk("row_start", {240'd0, RedPixels[0]}, {240'd0, 16'hFFFF});
    for (int i = 0; i < 4; i++) step();
    chk("row_step1", {240'd0, RedPixels[1]}, {240'd0, 16'hFFFF});

    // Checkerboard
    mode = 2'd3;
    step();
    chk("chk_red0", {240'd0, RedPixels[0]}, {240'd0, 16'h5555});
    chk("chk_grn0", {240'd0, GrnPixels[0]}, {240'd0, 16'hAAAA});
    chk("chk_red1", {240'd0, RedPixels[1]}, {240'd0, 16'hAAAA});
    fd_count = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("chk_disjoint", RedPixels & GrnPixels, 256'd0);
      chk("chk_cover", RedPixels | GrnPixels, {256{1'b1}});
    end
    chk("chk_fd_rate", fd_count, 2);

    // Mode change coincident with a tick
    mode = 2'd1;
    step();
    guard = 0;
    while ((m_cyc % TD) != TD - 1 && guard < 20) begin
      step();
      guard++;
    end
    chk("col_sync_bound", {255'd0, guard < 20}, {255'd0, 1'b1});
    mode = 2'd2;
    step();
    chk("chg_row0", {240'd0, RedPixels[0]}, {240'd0, 16'hFFFF});
    for (int i = 0; i < 3; i++) step();
    chk("chg_hold", {240'd0, RedPixels[0]}, {240'd0, 16'hFFFF});
    step();
    chk("chg_row1", {240'd0, RedPixels[1]}, {240'd0, 16'hFFFF});

    // Reset mid-sweep at pos 7
    guard = 0;
    while (cur_pos() != 7 && guard < 100) begin
      step();
      guard++;
    end
    chk("sweep_bound", {255'd0, guard < 100}, {255'd0, 1'b1});
    RST = 1'b1;
    step();
    chk("rst_dark", RedPixels | GrnPixels, 256'd0);
    RST = 1'b0;
    step();
    chk("rerun_row0", {240'd0, RedPixels[0]}, {240'd0, 16'hFFFF});

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      RST    = ($urandom_range(0, 99) < 2);
      enable = ($urandom_range(0, 99) < 90);
      if ($urandom_range(0, 99) < 6) mode = 2'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
